// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package clk_div_pkg;

   localparam int unsigned DEF_CNT_W = 8;
   localparam int unsigned DIV_MIN   = 2;
   localparam int unsigned HC_W      = 32;

   // ceil(n/2), one bit wider than the argument so n = all-ones cannot overflow
   function automatic logic [HC_W:0] half_ceil(input logic [HC_W-1:0] n);
      return ((HC_W + 1)'(n) + (HC_W + 1)'(1)) >> 1;
   endfunction

endpackage

// File: rtl/clk_div_prog_if.sv
// Control/status bundle of clk_div_prog; the sync input exists only with CLK_DIV_SYNC_EN.
interface clk_div_prog_if
   import clk_div_pkg::*;
#(
   parameter int unsigned CNT_W = DEF_CNT_W
) ();

   logic             en;
   logic [CNT_W-1:0] div_in;
   logic             div_load;
`ifdef CLK_DIV_SYNC_EN
   logic             sync;
`endif
   logic             clk_out;
   logic             tick;
   logic [CNT_W-1:0] div_cur;
   logic             pending;
   logic             div_err;

`ifdef CLK_DIV_SYNC_EN
   modport master (output en, div_in, div_load, sync,
                   input  clk_out, tick, div_cur, pending, div_err);
   modport slave  (input  en, div_in, div_load, sync,
                   output clk_out, tick, div_cur, pending, div_err);
`else
   modport master (output en, div_in, div_load,
                   input  clk_out, tick, div_cur, pending, div_err);
   modport slave  (input  en, div_in, div_load,
                   output clk_out, tick, div_cur, pending, div_err);
`endif

endinterface

// File: rtl/clk_div_cfg.sv
// Divisor configuration: shadow register, pending flag, divisor in force and load-error pulse.
module clk_div_cfg
   import clk_div_pkg::*;
#(
   parameter int unsigned CNT_W   = DEF_CNT_W,
   parameter int unsigned DIV_RST = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] div_in,
   input  logic             div_load,
   input  logic             boundary,
   output logic [CNT_W-1:0] div_cur,
   output logic             pending,
   output logic             div_err
);

   logic             load_ok_c;
   logic             pend_nxt;
   logic [CNT_W-1:0] shadow;
   logic [CNT_W-1:0] shadow_nxt;

   // A valid load in the boundary cycle is folded in, so it is applied at this same boundary
   always_comb begin
      load_ok_c  = div_load && (div_in >= CNT_W'(DIV_MIN));
      shadow_nxt = load_ok_c ? div_in : shadow;
      pend_nxt   = load_ok_c || pending;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow  <= CNT_W'(DIV_RST);
         div_cur <= CNT_W'(DIV_RST);
         pending <= 1'b0;
         div_err <= 1'b0;
      end else begin
         shadow  <= shadow_nxt;
         div_err <= div_load && !load_ok_c;
         if (boundary && pend_nxt) begin
            div_cur <= shadow_nxt;
            pending <= 1'b0;
         end else begin
            pending <= pend_nxt;
         end
      end
   end

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider producing a near-50% level and a period tick.
// Optional phase-align input enabled by defining CLK_DIV_SYNC_EN.
module clk_div_prog
   import clk_div_pkg::*;
#(
   parameter int unsigned CNT_W     = DEF_CNT_W,
   parameter int unsigned DIV_RST   = 10,
   parameter logic        RST_LEVEL = 1'b1
) (
   input logic           clk,
   input logic           rst,
   clk_div_prog_if.slave bus
);

   localparam int unsigned H_W = CNT_W + 1;

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [CNT_W-1:0] div_cur;
   logic [H_W-1:0]   half_c;
   logic             clk_out;
   logic             clk_out_nxt;
   logic             tick;
   logic             wrap_c;
   logic             sync_c;
   logic             boundary_c;

`ifdef CLK_DIV_SYNC_EN
   assign sync_c = bus.sync;
`else
   assign sync_c = 1'b0;
`endif

   assign wrap_c     = bus.en && (cnt == div_cur - CNT_W'(1));
   assign boundary_c = wrap_c || sync_c;
   // Old divisor is fine here: at a boundary cnt_nxt is 0, which is below any half-period
   assign half_c     = H_W'(half_ceil(HC_W'(div_cur)));

   always_comb begin
      cnt_nxt = cnt;
      if (boundary_c) begin
         cnt_nxt = '0;
      end else if (bus.en) begin
         cnt_nxt = cnt + CNT_W'(1);
      end
      clk_out_nxt = (H_W'(cnt_nxt) < half_c) ? RST_LEVEL : ~RST_LEVEL;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         clk_out <= RST_LEVEL;
         tick    <= 1'b0;
      end else begin
         cnt  <= cnt_nxt;
         tick <= boundary_c;
         if (bus.en || sync_c) begin
            clk_out <= clk_out_nxt;
         end
      end
   end

   clk_div_cfg #(
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_RST)
   ) u_cfg (
      .clk      (clk),
      .rst      (rst),
      .div_in   (bus.div_in),
      .div_load (bus.div_load),
      .boundary (boundary_c),
      .div_cur  (div_cur),
      .pending  (bus.pending),
      .div_err  (bus.div_err)
   );

   assign bus.div_cur = div_cur;
   assign bus.clk_out = clk_out;
   assign bus.tick    = tick;

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: phase/period reference model feeds an expectation queue.
module tb_clk_div_prog;

   localparam int unsigned CNT_W   = 8;
   localparam int unsigned DIV_RST = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   clk_div_prog_if #(.CNT_W(CNT_W)) bus ();

   clk_div_prog #(
      .CNT_W     (CNT_W),
      .DIV_RST   (DIV_RST),
      .RST_LEVEL (1'b1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic             clk_out;
      logic             tick;
      logic [CNT_W-1:0] div_cur;
      logic             pending;
      logic             div_err;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference state: position within the period, period length, staged divisor
   int   m_p;
   int   m_n;
   int   m_sh;
   bit   m_pend;
   bit   m_tick;
   bit   m_err;

   task automatic chk(input string nm, input int got, input int expv);
      checks++;
      if (got != expv) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, got, expv);
      end
   endtask

   function automatic exp_t model_out();
      exp_t o;
      o.clk_out = (m_p < (m_n + 1) / 2) ? 1'b1 : 1'b0;
      o.tick    = m_tick;
      o.div_cur = CNT_W'(m_n);
      o.pending = m_pend;
      o.div_err = m_err;
      return o;
   endfunction

   task automatic model_reset();
      m_p    = 0;
      m_n    = DIV_RST;
      m_sh   = DIV_RST;
      m_pend = 1'b0;
      m_tick = 1'b0;
      m_err  = 1'b0;
   endtask

   task automatic model_step(input bit e, input bit ld, input int din, input bit sy);
      bit period_end;
      bit new_period;
      m_err = ld && (din < 2);
      if (ld && din >= 2) begin
         m_sh   = din;
         m_pend = 1'b1;
      end
      period_end = e && (m_p == m_n - 1);
      new_period = period_end || sy;
      m_tick     = new_period;
      if (new_period) m_p = 0;
      else if (e)     m_p = m_p + 1;
      if (new_period && m_pend) begin
         m_n    = m_sh;
         m_pend = 1'b0;
      end
   endtask

   // One clock of stimulus; expectation for the following negedge is queued after the edge
   task automatic step(input bit e, input bit ld, input int din, input bit sy = 1'b0);
      bus.en       = e;
      bus.div_load = ld;
      bus.div_in   = CNT_W'(din);
`ifdef CLK_DIV_SYNC_EN
      bus.sync     = sy;
`endif
      model_step(e, ld, din, sy);
      @(posedge clk);
      #1;
      exp_q.push_back(model_out());
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0);
   endtask

   task automatic run_to_phase(input int ph);
      for (int i = 0; i < 600 && m_p != ph; i++) step(1'b1, 1'b0, 0);
   endtask

   // Reset asserted between edges; outputs must change without waiting for a clock
   task automatic do_reset();
      @(negedge clk);
      #1;
      rst          = 1'b1;
      bus.en       = 1'b0;
      bus.div_load = 1'b0;
`ifdef CLK_DIV_SYNC_EN
      bus.sync     = 1'b0;
`endif
      #1;
      chk("async_rst_clk_out", int'(bus.clk_out), 1);
      chk("async_rst_tick",    int'(bus.tick), 0);
      chk("async_rst_div_cur", int'(bus.div_cur), DIV_RST);
      chk("async_rst_pending", int'(bus.pending), 0);
      chk("async_rst_div_err", int'(bus.div_err), 0);
      model_reset();
      exp_q.push_back(model_out());
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("clk_out", int'(bus.clk_out), int'(e.clk_out));
            chk("tick",    int'(bus.tick),    int'(e.tick));
            chk("div_cur", int'(bus.div_cur), int'(e.div_cur));
            chk("pending", int'(bus.pending), int'(e.pending));
            chk("div_err", int'(bus.div_err), int'(e.div_err));
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      bus.en       = 1'b0;
      bus.div_load = 1'b0;
      bus.div_in   = '0;
`ifdef CLK_DIV_SYNC_EN
      bus.sync     = 1'b0;
`endif
      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      // Default divisor: 5 high / 5 low, first tick after ten cycles
      idle(40);

      // Switch to N=5 mid-period
      run_to_phase(3);
      step(1'b1, 1'b1, 5);
      idle(20);

      // Rejected divisors
      step(1'b1, 1'b1, 1);
      step(1'b1, 1'b0, 0);
      step(1'b1, 1'b1, 0);
      idle(6);

      // Back-to-back loads before a boundary: last one wins
      run_to_phase(1);
      step(1'b1, 1'b1, 7);
      step(1'b1, 1'b1, 4);
      idle(15);

      // Return to N=10, then load exactly in its wrap cycle
      step(1'b1, 1'b1, 10);
      for (int i = 0; i < 50 && m_n != 10; i++) step(1'b1, 1'b0, 0);
      run_to_phase(9);
      step(1'b1, 1'b1, 6);
      idle(14);

      // Hold with en low, then queue a divisor and reset before it lands
      run_to_phase(2);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 0);
      step(1'b1, 1'b1, 9);
      idle(1);
      do_reset();
      idle(12);

`ifdef CLK_DIV_SYNC_EN
      // Phase realignment at cnt=7 of N=10
      run_to_phase(7);
      step(1'b1, 1'b0, 0, 1'b1);
      idle(12);
      step(1'b1, 1'b1, 3);
      step(1'b0, 1'b0, 0, 1'b1);
      idle(8);
`endif

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         bit e;
         bit ld;
         bit sy;
         int din;
         e   = ($urandom_range(0, 9) < 8);
         ld  = ($urandom_range(0, 9) == 0);
         din = int'($urandom_range(0, 20));
`ifdef CLK_DIV_SYNC_EN
         sy  = ($urandom_range(0, 49) == 0);
`else
         sy  = 1'b0;
`endif
         step(e, ld, din, sy);
      end
      step(1'b0, 1'b0, 0);

      @(negedge clk);
      #1;
      chk("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
